// File: rtl/bcd_cascade_counter.sv
// Parametrised N-digit BCD up/down counter with parallel load, wrap/saturate and terminal-count strobe.
// Define BCD_CASCADE_LEAP_EN to add the Gregorian leap-year output on the low four digits.
module bcd_cascade_counter #(
    parameter int unsigned DIGITS = 4,
    parameter bit WRAP = 1'b1,
    localparam int unsigned W = 4 * DIGITS,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] load_bcd,
    output logic [W-1:0] bcd_out,
    output logic         tc,
    output logic         at_max,
    output logic         at_min
`ifdef BCD_CASCADE_LEAP_EN
    ,
    output logic         leap
`endif
);

    logic [DIGITS-1:0] is_nine;
    logic [DIGITS-1:0] is_zero;
    logic [W-1:0]      bcd_next;
    logic              terminal;

    // Per-digit terminal flags from the registered count
    always_comb begin : digit_flags
        is_nine = '0;
        is_zero = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            is_nine[k] = (bcd_out[4*k +: 4] == 4'd9);
            is_zero[k] = (bcd_out[4*k +: 4] == 4'd0);
        end
    end

    assign at_max   = &is_nine;
    assign at_min   = &is_zero;
    assign terminal = up_dn ? at_max : at_min;
    // Reset masks the strobe so a held-in-reset counter never cascades
    assign tc       = rst & en & ~load & terminal;

    // Next count: load (clamped per digit) beats a parallel-carry step beats hold
    always_comb begin : next_value
        logic       run;
        logic [3:0] d;
        logic [3:0] ld_d;
        run      = 1'b1;
        d        = '0;
        ld_d     = '0;
        bcd_next = bcd_out;
        if (load) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                ld_d = load_bcd[4*k +: 4];
                bcd_next[4*k +: 4] = (ld_d > 4'd9) ? 4'd9 : ld_d;
            end
        end else if (en && (WRAP || !terminal)) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                d = bcd_out[4*k +: 4];
                if (run) begin
                    if (up_dn) bcd_next[4*k +: 4] = is_nine[k] ? 4'd0 : d + 4'd1;
                    else       bcd_next[4*k +: 4] = is_zero[k] ? 4'd9 : d - 4'd1;
                end
                run = run & (up_dn ? is_nine[k] : is_zero[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin : count_reg
        if (!rst) bcd_out <= RST_VAL;
        else      bcd_out <= bcd_next;
    end

`ifdef BCD_CASCADE_LEAP_EN
    generate
        if (DIGITS >= 4) begin : g_leap
            // (2*tens + ones) mod 4 only depends on the tens LSB and the ones low bits
            logic [1:0] low_mod;
            logic [1:0] high_mod;
            assign low_mod  = 2'({bcd_out[4], 1'b0}) + bcd_out[1:0];
            assign high_mod = 2'({bcd_out[12], 1'b0}) + bcd_out[9:8];
            assign leap     = (low_mod == 2'd0) & ((|bcd_out[7:0]) | (high_mod == 2'd0));
        end else begin : g_no_leap
            assign leap = 1'b0;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench for bcd_cascade_counter: a wrapping and a saturating instance on shared stimulus.
module tb_bcd_cascade_counter;

    typedef struct {
        logic        ld;
        logic [15:0] lbcd;
        logic        en;
        logic        up;
        logic        exp_tc;
        logic [15:0] exp_bcd;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [15:0] load_bcd;
    logic [15:0] bcd1, bcd0;
    logic        tc1, tc0, max1, max0, min1, min0;
`ifdef BCD_CASCADE_LEAP_EN
    logic        leap1, leap0;
`endif

    int          n_vec;
    int          n_bad;
    logic [15:0] model [2];
    logic [15:0] exp_q [$];
    int          sel_q [$];
    vec_t        vt [$];

    bcd_cascade_counter #(.DIGITS(4), .WRAP(1'b1), .RST_VAL(16'h0000)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bcd(load_bcd),
        .bcd_out(bcd1), .tc(tc1), .at_max(max1), .at_min(min1)
`ifdef BCD_CASCADE_LEAP_EN
        , .leap(leap1)
`endif
    );

    bcd_cascade_counter #(.DIGITS(4), .WRAP(1'b0), .RST_VAL(16'h0000)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bcd(load_bcd),
        .bcd_out(bcd0), .tc(tc0), .at_max(max0), .at_min(min0)
`ifdef BCD_CASCADE_LEAP_EN
        , .leap(leap0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle on inst sel (0 = wrap, 1 = saturate); check strobes pre-edge, count post-edge
    task automatic step(input int sel, input vec_t v, input string tag);
        logic [15:0] got;
        int          s;
        @(negedge clk);
        load = v.ld; load_bcd = v.lbcd; en = v.en; up_dn = v.up;
        #1;
        chk({tag, " tc"},     16'(sel == 1 ? tc0  : tc1),  16'(v.exp_tc));
        chk({tag, " at_max"}, 16'(sel == 1 ? max0 : max1), 16'(model[sel] == 16'h9999));
        chk({tag, " at_min"}, 16'(sel == 1 ? min0 : min1), 16'(model[sel] == 16'h0000));
        exp_q.push_back(v.exp_bcd);
        sel_q.push_back(sel);
        @(posedge clk);
        #1;
        s   = sel_q.pop_front();
        got = (s == 1) ? bcd0 : bcd1;
        chk({tag, " bcd_out"}, got, exp_q.pop_front());
        model[sel] = v.exp_bcd;
    endtask

`ifdef BCD_CASCADE_LEAP_EN
    typedef struct {
        logic [15:0] y;
        logic        exp;
    } leap_t;
    leap_t lt [$];
`endif

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin : main
        n_vec = 0; n_bad = 0;
        model[0] = 16'h0000; model[1] = 16'h0000;
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bcd = '0;

        #2;
        chk("reset bcd_out", bcd1, 16'h0000);
        chk("reset at_min", 16'(min1), 16'h0001);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 3; i++)
            step(0, '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'(i + 1)}, $sformatf("pre_up%0d", i));

        // Mid-cycle async reset with en high: value clears without a clock edge, tc stays low
        @(negedge clk);
        en = 1'b1; up_dn = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_rst bcd_out", bcd1, 16'h0000);
        chk("async_rst sat bcd_out", bcd0, 16'h0000);
        chk("async_rst tc", 16'(tc1), 16'h0000);
        chk("async_rst at_min", 16'(min1), 16'h0001);
        model[0] = 16'h0000; model[1] = 16'h0000;
        @(negedge clk);
        rst = 1'b1; en = 1'b0;

        for (int i = 0; i < 10; i++)
            step(0, '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, (i == 9) ? 16'h0010 : 16'(i + 1)},
                 $sformatf("up%0d", i));

        vt.push_back('{1'b1, 16'h9998, 1'b0, 1'b1, 1'b0, 16'h9998});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h9999});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001});
        vt.push_back('{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h9999});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h9998});
        vt.push_back('{1'b1, 16'hA5F3, 1'b0, 1'b1, 1'b0, 16'h9593});
        vt.push_back('{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h1234});
        vt.push_back('{1'b1, 16'h0500, 1'b1, 1'b1, 1'b0, 16'h0500});
        vt.push_back('{1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h9999});
        vt.push_back('{1'b1, 16'h0500, 1'b1, 1'b1, 1'b0, 16'h0500});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0501});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0500});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0499});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0500});
        vt.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0500});
        vt.push_back('{1'b1, 16'h0099, 1'b0, 1'b1, 1'b0, 16'h0099});
        vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0100});
        vt.push_back('{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h9999});
        vt.push_back('{1'b1, 16'h0F90, 1'b0, 1'b0, 1'b0, 16'h0990});
        foreach (vt[i]) step(0, vt[i], $sformatf("vec%0d", i));

        // Saturating instance: hold at the terminal value with tc high every enabled cycle
        step(0, '{1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h9999}, "sat_load_max");
        model[1] = 16'h9999;
        for (int i = 0; i < 4; i++)
            step(1, '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h9999}, $sformatf("sat_up%0d", i));
        step(1, '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}, "sat_load_min");
        for (int i = 0; i < 4; i++)
            step(1, '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000}, $sformatf("sat_dn%0d", i));
        step(1, '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001}, "sat_leave");

`ifdef BCD_CASCADE_LEAP_EN
        lt.push_back('{16'h1900, 1'b0});
        lt.push_back('{16'h2000, 1'b1});
        lt.push_back('{16'h2024, 1'b1});
        lt.push_back('{16'h2023, 1'b0});
        lt.push_back('{16'h2096, 1'b1});
        foreach (lt[i]) begin
            step(0, '{1'b1, lt[i].y, 1'b0, 1'b1, 1'b0, lt[i].y}, $sformatf("leap_ld%0d", i));
            chk($sformatf("leap %h", lt[i].y), 16'(leap1), 16'(lt[i].exp));
        end
        step(0, '{1'b1, 16'h2099, 1'b0, 1'b1, 1'b0, 16'h2099}, "leap_ld2099");
        chk("leap 2099", 16'(leap1), 16'h0000);
        step(0, '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h2100}, "leap_up2100");
        chk("leap 2100", 16'(leap1), 16'h0000);
`endif

        @(negedge clk);
        en = 1'b0; load = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_cascade_counter.md
Name: bcd_cascade_counter

Overview:
- Parametrised N-digit BCD up/down counter. Successor to the fixed 4-digit year counter in the century clock.
- Adds count direction, synchronous parallel load, and selectable wrap or saturate at the terminal value.
- Drives a terminal-count strobe so blocks can be chained, e.g. a year block fed by the month/day carry, or millennium extension.
- Packed BCD output feeds the 7-segment display path directly.

Parameters:
- DIGITS, 4, number of BCD digits; legal range 1..8.
- WRAP, 1: 1 = wrap around at the terminal value; 0 = saturate at it.
- RST_VAL, 0, packed BCD value (4*DIGITS bits) loaded on reset. Each nibble must be ≤9.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; 0 forces RST_VAL immediately.
- en  in  1  count enable; one step per clk while high.
- up_dn  in  1  1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load strobe.
- load_bcd  in  4*DIGITS  packed BCD load value; digit 0 in bits [3:0].
- bcd_out  out  4*DIGITS  registered packed BCD count; digit k in bits [4k+3:4k].
- tc  out  1  terminal-count strobe, combinational.
- at_max  out  1  combinational; high when all digits are 9.
- at_min  out  1  combinational; high when all digits are 0.

Behaviour:
- Reset:
  - rst low → bcd_out = RST_VAL asynchronously, independent of clk.
  - Outputs are valid in the same cycle the reset asserts. at_max, at_min and tc follow from bcd_out; tc = 0 because en is ignored.
  - Release is synchronised by the user. The first step occurs at the first clk edge with rst high.
- Priority per rising clk edge with rst high: load > en > hold.
- Load:
  - bcd_out <= load_bcd, one-cycle latency.
  - Any load nibble >9 is clamped to 9 on that digit; other digits are unaffected.
  - en is ignored in a load cycle, and tc is forced to 0 in that cycle.
- Count up (en=1, up_dn=1):
  - Digit 0 increments.
  - Digit k increments iff all digits below k are 9; each such lower digit rolls 9→0.
  - Single-cycle ripple-free carry: enable terms are computed from current registered digits, not a chain of registers.
- Count down (en=1, up_dn=0):
  - Digit 0 decrements.
  - Digit k decrements iff all digits below k are 0; each such lower digit rolls 0→9.
- Terminal value:
  - Up: all 9s. Down: all 0s.
  - tc = en & ~load & (up_dn ? at_max : at_min). tc is high in the cycle whose edge wraps or saturates.
  - WRAP=1: all 9s +1 → all 0s; all 0s −1 → all 9s.
  - WRAP=0: value holds at the terminal value. tc still asserts every enabled cycle while held there.
- Direction change mid-count is legal and takes effect on the next enabled edge; there is no extra latency.
- Illegal stored nibbles cannot occur: reset, load clamp and step logic keep every digit in 0..9.
- en held high for consecutive cycles → exactly one step per cycle; there are no skipped or double steps.

Optional Feature:
- Macro: BCD_CASCADE_LEAP_EN.
- Defined, and DIGITS ≥ 4: adds output port leap (1 bit), combinational from bcd_out, using the Gregorian rule on the low 4 digits as a year value Y:
  - Low pair: L = 10*d1 + d0. High pair: H = 10*d3 + d2.
  - Div-by-4 test on a BCD pair: (2*tens + ones) mod 4 == 0.
  - leap = 1 iff L%4==0 and (L≠0 or H%4==0). Example: 1900 → 0, 2000 → 1, 2024 → 1, 2023 → 0.
  - leap = 0 during reset is not required; leap tracks RST_VAL.
- Defined with DIGITS < 4: leap port is present and tied 0.
- Not defined: no leap port and no leap logic.

Test Plan:
1. DIGITS=4, WRAP=1, RST_VAL=0. Assert rst low mid-cycle → bcd_out=0x0000 without a clk edge. Release, en=1, up for 10 cycles → 0x0010.
2. Load 0x9998, up, en for 3 cycles → 0x9999 with tc=0, then 0x0000 with tc=1 in the 0x9999 cycle, then 0x0001.
3. Load 0x0001, down, WRAP=1 → 0x0000, then 0x9999. tc=1 in the 0x0000 cycle only.
4. WRAP=0: load 0x9999, up, en for 4 cycles → holds 0x9999, tc=1 every cycle. Same check down at 0x0000.
5. Load 0xA5F3 → bcd_out=0x9593. Assert load and en together at 0x1234 with load_bcd=0x0500 → 0x0500, tc=0.
6. With BCD_CASCADE_LEAP_EN: load 1900/2000/2024/2023 → leap 0/1/1/0. Count up 2099→2100 → leap goes 0→0 and the carry into d3 is correct.
